// File: rtl/tdm_sched_pkg.sv
// Shared types and helpers for the TDM CIC scheduler.
package tdm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int FRAME_W = 16;

    function automatic int chw(input int c);
        return (c > 2) ? $clog2(c) : 1;
    endfunction

endpackage

// File: rtl/tdm_sched_slice.sv
// Single-entry valid/ready register slice feeding the shared CIC.
module tdm_sched_slice #(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tdm_cic_scheduler.sv
// Round-robin TDM scheduler sharing one CIC between C streams, with frame-aligned start/stop.
// Optional input watchdog enabled by defining TDM_SCHED_WDOG_EN.
//
// state | meaning
// IDLE  | no input accepted, waiting for en
// RUN   | rotating through channels
// STOP  | en dropped mid-frame, finishing the rotation up to channel C-1
module tdm_cic_scheduler
    import tdm_sched_pkg::*;
#(
    parameter int W   = 16,
    parameter int C   = 4,
    parameter int TMO = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [C*W-1:0]       s_axis_tdata,
    input  logic [C-1:0]         s_axis_tvalid,
    output logic [C-1:0]         s_axis_tready,
    output logic [W-1:0]         m_axis_tdata,
    output logic [chw(C)-1:0]    m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic [W-1:0]         r_axis_tdata,
    input  logic                 r_axis_tvalid,
    output logic                 r_axis_tready,
    output logic [C*W-1:0]       o_axis_tdata,
    output logic [C-1:0]         o_axis_tvalid,
    input  logic [C-1:0]         o_axis_tready,
`ifdef TDM_SCHED_WDOG_EN
    output logic                 wdog_err,
`endif
    output logic                 busy,
    output logic [FRAME_W-1:0]   frames
);

    localparam int CW = chw(C);
    localparam logic [CW-1:0] LAST_CH = CW'(C - 1);

    if (C < 2 || C > 16 || TMO < 1) begin : g_param_check
        $error("tdm_cic_scheduler: C must be 2..16 and TMO >= 1");
    end

    state_t        state, state_nx;
    logic [CW-1:0] in_ch, out_ch;
    logic          can_accept, in_hs, inject, advance, wrap, r_hs;
    logic [W-1:0]  in_sample, load_sample;
    logic [W+CW-1:0] slice_d, slice_q;

    assign in_sample = s_axis_tdata[int'(in_ch)*W +: W];
    assign in_hs     = (state != IDLE) && can_accept && s_axis_tvalid[in_ch];
    assign advance   = in_hs || inject;
    assign wrap      = advance && (in_ch == LAST_CH);

`ifdef TDM_SCHED_WDOG_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] wd_cnt;
    logic          wd_idle;

    assign wd_idle = (state != IDLE) && can_accept && !s_axis_tvalid[in_ch];
    assign inject  = wd_idle && (wd_cnt == '0);

    // Down-counter reloads on every pointer advance; terminal count injects a zero sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt   <= TW'(TMO - 1);
            wdog_err <= 1'b0;
        end else begin
            wdog_err <= inject;
            if (advance || state == IDLE) begin
                wd_cnt <= TW'(TMO - 1);
            end else if (wd_idle) begin
                wd_cnt <= wd_cnt - TW'(1);
            end
        end
    end
`else
    assign inject = 1'b0;
`endif

    assign load_sample = inject ? {W{1'b0}} : in_sample;
    assign slice_d     = {in_ch, load_sample};

    tdm_sched_slice #(
        .DW(W + CW)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (advance),
        .in_data   (slice_d),
        .in_ready  (can_accept),
        .out_valid (m_axis_tvalid),
        .out_data  (slice_q),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tuser, m_axis_tdata} = slice_q;

    always_comb begin
        s_axis_tready        = '0;
        s_axis_tready[in_ch] = (state != IDLE) && can_accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ch  <= '0;
            frames <= '0;
        end else if (advance) begin
            in_ch <= wrap ? '0 : in_ch + CW'(1);
            if (wrap) begin
                frames <= frames + FRAME_W'(1);
            end
        end
    end

    // Return path is purely combinational and ignores the FSM so results drain after stop.
    assign r_axis_tready = o_axis_tready[out_ch];
    assign r_hs          = r_axis_tvalid && r_axis_tready;
    assign o_axis_tdata  = {C{r_axis_tdata}};

    always_comb begin
        o_axis_tvalid         = '0;
        o_axis_tvalid[out_ch] = r_axis_tvalid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ch <= '0;
        end else if (r_hs) begin
            out_ch <= (out_ch == LAST_CH) ? '0 : out_ch + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (en) state_nx = RUN;
            RUN:  if (!en) state_nx = (in_ch == '0 && !advance) ? IDLE : STOP;
            STOP: begin
                if (en) begin
                    state_nx = RUN;
                end else if (wrap) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tdm_cic_scheduler.sv
// Scoreboard bench for tdm_cic_scheduler: directed vectors, queued expectations, negedge monitor.
module tb_tdm_cic_scheduler;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst, en;
    logic [C*W-1:0] s_axis_tdata;
    logic [C-1:0]   s_axis_tvalid, s_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic [CW-1:0]  m_axis_tuser;
    logic           m_axis_tvalid, m_axis_tready;
    logic [W-1:0]   r_axis_tdata;
    logic           r_axis_tvalid, r_axis_tready;
    logic [C*W-1:0] o_axis_tdata;
    logic [C-1:0]   o_axis_tvalid, o_axis_tready;
    logic           busy;
    logic [15:0]    frames;
`ifdef TDM_SCHED_WDOG_EN
    logic           wdog_err;
`endif

    int passed = 0;
    int total  = 0;
    logic [W+CW-1:0] mq[$];
    logic [W+CW-1:0] rq[$];

    always #5 clk = ~clk;

    tdm_cic_scheduler #(.W(W), .C(C), .TMO(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .r_axis_tdata  (r_axis_tdata),
        .r_axis_tvalid (r_axis_tvalid),
        .r_axis_tready (r_axis_tready),
        .o_axis_tdata  (o_axis_tdata),
        .o_axis_tvalid (o_axis_tvalid),
        .o_axis_tready (o_axis_tready),
`ifdef TDM_SCHED_WDOG_EN
        .wdog_err      (wdog_err),
`endif
        .busy          (busy),
        .frames        (frames)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [W-1:0] base);
        for (int k = 0; k < C; k++) s_axis_tdata[k*W +: W] = base + W'(k);
    endtask

    task automatic push_frame(input logic [W-1:0] base);
        for (int k = 0; k < C; k++) mq.push_back({CW'(k), base + W'(k)});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 0);
        chk({tag, "_m_tdata"},  32'(m_axis_tdata), 0);
        chk({tag, "_m_tuser"},  32'(m_axis_tuser), 0);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_frames"},   32'(frames), 0);
        chk({tag, "_s_tready"}, 32'(s_axis_tready), 0);
    endtask

    // Monitor: pops expectations on every handshake and checks hold-while-stalled.
    logic            prev_stall = 1'b0;
    logic [W+CW-1:0] prev_m, em, er;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("m_stable", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tdata}), 32'({1'b1, prev_m}));
            if (m_axis_tvalid && m_axis_tready) begin
                if (mq.size() == 0) begin
                    total++;
                    $display("FAIL m_unexpected: got tuser %0d data 0x%0h, expected none", m_axis_tuser, m_axis_tdata);
                end else begin
                    em = mq.pop_front();
                    chk("m_tuser", 32'(m_axis_tuser), 32'(em[W +: CW]));
                    chk("m_tdata", 32'(m_axis_tdata), 32'(em[W-1:0]));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_m     = {m_axis_tuser, m_axis_tdata};
            for (int k = 0; k < C; k++) begin
                if (o_axis_tvalid[k] && o_axis_tready[k]) begin
                    if (rq.size() == 0) begin
                        total++;
                        $display("FAIL o_unexpected: got ch %0d data 0x%0h, expected none", k, o_axis_tdata[k*W +: W]);
                    end else begin
                        er = rq.pop_front();
                        chk("o_channel", 32'(k), 32'(er[W +: CW]));
                        chk("o_tdata", 32'(o_axis_tdata[k*W +: W]), 32'(er[W-1:0]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    int  idx, cyc, n;
    logic hs;

    initial begin
        rst = 1'b1; en = 1'b0; s_axis_tvalid = '0; s_axis_tdata = '0;
        m_axis_tready = 1'b1; r_axis_tvalid = 1'b0; r_axis_tdata = '0;
        o_axis_tready = 4'b0001;
        repeat (3) step();
        check_reset_vals("rst0");
        chk("rst0_r_tready_hi", 32'(r_axis_tready), 1);
        o_axis_tready = 4'b1110;
        #1 chk("rst0_r_tready_lo", 32'(r_axis_tready), 0);
        o_axis_tready = 4'hF;
        rst = 1'b0;

        // Full-rate rotation, ch2 stall, then stop after ch1.
        set_data(16'h1000);
        s_axis_tvalid = 4'hF;
        push_frame(16'h1000); push_frame(16'h1000); push_frame(16'h1000);
        en = 1'b1;
        step();
        chk("run_busy", 32'(busy), 1);
        for (int k = 0; k < C; k++) begin
            chk("rot_s_tready", 32'(s_axis_tready), 32'(1) << k);
            step();
            chk("rot_m_tvalid", 32'(m_axis_tvalid), 1);
        end
        chk("frames_1", 32'(frames), 1);
        s_axis_tvalid[2] = 1'b0;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_s_tready", 32'(s_axis_tready), 32'h4);
            chk("hold_m_tvalid", 32'(m_axis_tvalid), 0);
        end
        s_axis_tvalid[2] = 1'b1;
        step(); step();
        chk("frames_2", 32'(frames), 2);
        step(); step();
        en = 1'b0;
        step();
        chk("stop_busy_ch2", 32'(busy), 1);
        step();
        chk("stop_busy_ch3", 32'(busy), 0);
        chk("frames_3", 32'(frames), 3);
        step();
        chk("idle_s_tready", 32'(s_axis_tready), 0);
        chk("idle_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("idle_frames", 32'(frames), 3);

        // Downstream back-pressure; en pulsed for one cycle gives exactly one frame.
        set_data(16'h2000);
        push_frame(16'h2000);
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_axis_tready = (i % 2 == 0);
            step();
        end
        m_axis_tready = 1'b1;
        step(); step();
        chk("bp_busy", 32'(busy), 0);
        chk("bp_frames", 32'(frames), 4);
        chk("bp_queue_empty", 32'(mq.size()), 0);

        // Return path with channel 1 stalled for the first 5 cycles.
        for (int i = 0; i < 8; i++) rq.push_back({CW'(i % 4), W'(16'hA0 + i)});
        o_axis_tready = 4'b1101;
        idx = 0; cyc = 0;
        while (idx < 8 && cyc < 40) begin
            if (cyc == 5) o_axis_tready = 4'hF;
            r_axis_tdata  = W'(16'hA0 + idx);
            r_axis_tvalid = 1'b1;
            #1;
            chk("r_tready", 32'(r_axis_tready), 32'(o_axis_tready[idx % 4]));
            chk("o_tvalid", 32'(o_axis_tvalid), 32'(1) << (idx % 4));
            hs = r_axis_tready;
            step();
            if (hs) idx++;
            cyc++;
        end
        r_axis_tvalid = 1'b0;
        chk("r_cycles", 32'(cyc), 12);
        chk("r_queue_empty", 32'(rq.size()), 0);

        // Mid-operation reset with a held sample and out_ch advanced.
        set_data(16'h3000);
        m_axis_tready = 1'b0;
        en = 1'b1;
        step(); step();
        chk("pre_rst_m_tvalid", 32'(m_axis_tvalid), 1);
        rq.push_back({CW'(0), W'(16'hB0)});
        r_axis_tdata = W'(16'hB0); r_axis_tvalid = 1'b1;
        step();
        r_axis_tvalid = 1'b0;
        rst = 1'b1; en = 1'b0; o_axis_tready = 4'b0001;
        step();
        check_reset_vals("rst1");
        chk("rst1_r_tready", 32'(r_axis_tready), 1);
        r_axis_tvalid = 1'b1;
        #1 chk("rst1_o_tvalid", 32'(o_axis_tvalid), 32'h1);
        r_axis_tvalid = 1'b0;
        o_axis_tready = 4'hF; m_axis_tready = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 0);

`ifdef TDM_SCHED_WDOG_EN
        // Channel 3 silent: zero sample tagged 3 after 8 idle cycles.
        set_data(16'h1000);
        s_axis_tvalid = 4'b0111;
        mq.push_back({CW'(0), 16'h1000});
        mq.push_back({CW'(1), 16'h1001});
        mq.push_back({CW'(2), 16'h1002});
        mq.push_back({CW'(3), 16'h0000});
        en = 1'b1;
        step();
        n = 0;
        while (!wdog_err && n < 40) begin
            step();
            n++;
        end
        chk("wdog_steps", 32'(n), 11);
        chk("wdog_next_ch0", 32'(s_axis_tready), 32'h1);
        step();
        chk("wdog_pulse_once", 32'(wdog_err), 0);
        rst = 1'b1; en = 1'b0;
        step();
        check_reset_vals("rst2");
        chk("rst2_wdog_err", 32'(wdog_err), 0);
        rst = 1'b0;
        step();
`endif

        chk("m_queue_empty", 32'(mq.size()), 0);
        chk("r_queue_final", 32'(rq.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
